// File: rtl/sort_readout_pkg.sv
// Shared defaults and FSM encoding for the sort readout block.
package sort_readout_pkg;
  localparam int N_DEF    = 16;
  localparam int DW_DEF   = 8;
  localparam int AW_DEF   = 4;
  localparam int SUMW_DEF = DW_DEF + AW_DEF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    CAPT  = 3'd2,
    SEND  = 3'd3,
    FIN   = 3'd4
  } state_t;
endpackage

// File: rtl/sort_readout_if.sv
// Output word stream with valid/ready handshake and end-of-frame marker.
interface sort_readout_if #(parameter int DW = 8);
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/sort_readout_stats_acc.sv
// Frame statistics over the sorted words, keyed by address so stream order does not matter.
module sort_stats_acc #(
  parameter int N  = 16,
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             capture,
  input  logic [AW-1:0]    idx,
  input  logic [DW-1:0]    data,
  output logic [DW-1:0]    min_o,
  output logic [DW-1:0]    max_o,
  output logic [DW-1:0]    median_o,
  output logic [DW-1:0]    range_o,
  output logic [DW+AW-1:0] sum_o
);
  logic [DW-1:0] mid_lo, mid_hi;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      min_o  <= '0;
      max_o  <= '0;
      mid_lo <= '0;
      mid_hi <= '0;
      sum_o  <= '0;
    end else if (capture) begin
      sum_o <= sum_o + {{AW{1'b0}}, data};
      if (idx == '0)            min_o  <= data;
      if (idx == AW'(N - 1))    max_o  <= data;
      if (idx == AW'(N/2 - 1))  mid_lo <= data;
      if (idx == AW'(N/2))      mid_hi <= data;
    end
  end

  // floor((a+b)/2) without a carry bit: halve each, then add back the shared LSB
  assign median_o = (mid_lo >> 1) + (mid_hi >> 1) + DW'(mid_lo[0] & mid_hi[0]);
  assign range_o  = (max_o >= min_o) ? (max_o - min_o) : '0;
endmodule

// File: rtl/sort_readout.sv
// Reads a sorted frame back from IRAM on sort_done, streams it out and reports stats.
// DESC_EN defined: addresses are walked N-1..0 so the stream is descending.
module sort_readout
  import sort_readout_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sort_done,
  output logic             IRAM_rd,
  output logic [AW-1:0]    IRAM_A,
  input  logic [DW-1:0]    IRAM_Q,
  sort_readout_if.master   strm,
  output logic [DW-1:0]    min_o,
  output logic [DW-1:0]    max_o,
  output logic [DW-1:0]    median_o,
  output logic [DW-1:0]    range_o,
  output logic [DW+AW-1:0] sum_o,
  output logic             stats_valid,
  output logic             busy,
  output logic             done
);
`ifdef DESC_EN
  localparam logic [AW-1:0] FIRST_IDX = AW'(N - 1);
  localparam logic [AW-1:0] LAST_IDX  = '0;
`else
  localparam logic [AW-1:0] FIRST_IDX = '0;
  localparam logic [AW-1:0] LAST_IDX  = AW'(N - 1);
`endif

  state_t        state_q, state_d;
  logic          sort_done_q;
  logic [AW-1:0] idx;
  logic          start, xfer, at_last;

  assign start   = (state_q == IDLE) && sort_done && !sort_done_q;
  assign xfer    = strm.out_valid && strm.out_ready;
  assign at_last = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (start) state_d = FETCH;
      FETCH:      state_d = CAPT;
      CAPT, SEND: begin
        if (xfer)                  state_d = at_last ? FIN : FETCH;
        else if (state_q == CAPT)  state_d = SEND;
      end
      FIN:        state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  assign IRAM_rd = (state_q == FETCH);
  assign IRAM_A  = idx;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == FIN);

  always_ff @(posedge clk) begin
    if (reset) begin
      sort_done_q    <= 1'b0;
      idx            <= '0;
      strm.out_valid <= 1'b0;
      strm.out_data  <= '0;
      strm.out_last  <= 1'b0;
      stats_valid    <= 1'b0;
    end else begin
      sort_done_q <= sort_done;
      if (start) begin
        idx         <= FIRST_IDX;
        stats_valid <= 1'b0;
      end
      if (state_q == FETCH) begin
        strm.out_valid <= 1'b1;
        strm.out_data  <= IRAM_Q;
        strm.out_last  <= at_last;
      end
      // idx stops on the final address; stats_valid rises as FIN is entered
      if ((state_q == CAPT || state_q == SEND) && xfer) begin
        strm.out_valid <= 1'b0;
        strm.out_last  <= 1'b0;
        if (at_last) stats_valid <= 1'b1;
`ifdef DESC_EN
        else         idx <= idx - AW'(1);
`else
        else         idx <= idx + AW'(1);
`endif
      end
    end
  end

  sort_stats_acc #(.N(N), .DW(DW), .AW(AW)) u_stats (
    .clk      (clk),
    .reset    (reset),
    .clear    (start),
    .capture  (state_q == FETCH),
    .idx      (idx),
    .data     (IRAM_Q),
    .min_o    (min_o),
    .max_o    (max_o),
    .median_o (median_o),
    .range_o  (range_o),
    .sum_o    (sum_o)
  );
endmodule

// File: tb/tb_sort_readout.sv
// Directed + randomized bench for sort_readout against a queue-based frame model.
module tb_sort_readout;
  import sort_readout_pkg::*;
  localparam int N  = 16;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset, sort_done;
  logic          IRAM_rd;
  logic [AW-1:0] IRAM_A;
  logic [DW-1:0] IRAM_Q = '0;
  logic [DW-1:0] min_o, max_o, median_o, range_o;
  logic [DW+AW-1:0] sum_o;
  logic          stats_valid, busy, done;

  sort_readout_if #(.DW(DW)) sif ();

  sort_readout #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .sort_done(sort_done),
    .IRAM_rd(IRAM_rd), .IRAM_A(IRAM_A), .IRAM_Q(IRAM_Q),
    .strm(sif),
    .min_o(min_o), .max_o(max_o), .median_o(median_o), .range_o(range_o),
    .sum_o(sum_o), .stats_valid(stats_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [N];
  always @(negedge clk) if (IRAM_rd) IRAM_Q = mem[IRAM_A];

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  int e_min, e_max, e_med, e_sum;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: ramp 0..N-1, mode 1: all 0xFF, mode 2: random; memory holds the sorted frame
  task automatic load_frame(input int mode);
    logic [DW-1:0] v[$];
    v = {};
    for (int i = 0; i < N; i++)
      v.push_back(mode == 0 ? DW'(i) : mode == 1 ? 8'hFF : DW'($urandom_range(0, 255)));
    v.sort();
    for (int i = 0; i < N; i++) mem[i] = v[i];
    exp_q = {};
    e_min = 255; e_max = 0; e_sum = 0;
    for (int i = 0; i < N; i++) begin
`ifdef DESC_EN
      exp_q.push_front(v[i]);
`else
      exp_q.push_back(v[i]);
`endif
      if (int'(v[i]) < e_min) e_min = int'(v[i]);
      if (int'(v[i]) > e_max) e_max = int'(v[i]);
      e_sum += int'(v[i]);
    end
    e_med = (int'(v[N/2-1]) + int'(v[N/2])) / 2;
  endtask

  task automatic chk_all_zero(input string tn);
    chk({tn, " rst_ctl"}, {IRAM_rd, IRAM_A, sif.out_valid, sif.out_last, sif.out_data,
                            stats_valid, busy, done}, 0);
    chk({tn, " rst_stats"}, {min_o, max_o, median_o, range_o}, 0);
    chk({tn, " rst_sum"}, sum_o, 0);
  endtask

  task automatic run_frame(input string tn, input int stall_at, input int stall_len,
                           input bit rand_rdy, input bit repulse, input int reset_at);
    logic [DW-1:0] got[$];
    int last_cnt = 0, last_pos = -1, dones = 0, post = 0, stall_left = stall_len;
    bit held_pending = 0;
    logic [DW-1:0] held_d;
    logic held_l;
    got = {};
    @(negedge clk); sort_done = 1'b1; sif.out_ready = 1'b0;
    @(negedge clk);
    chk({tn, " lat1_valid"}, sif.out_valid, 0);
    chk({tn, " start_busy"}, busy, 1);
    chk({tn, " start_stats_valid"}, stats_valid, 0);
    @(negedge clk);
    chk({tn, " lat2_valid"}, sif.out_valid, 1);
    sort_done = 1'b0;
    for (int cyc = 0; cyc < 600 && post < 4; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (held_pending) begin
        chk({tn, " hold_valid"}, sif.out_valid, 1);
        chk({tn, " hold_data"}, sif.out_data, held_d);
        chk({tn, " hold_last"}, sif.out_last, held_l);
      end
      if (stall_left > 0 && got.size() == stall_at && sif.out_valid) begin
        stall_left--;
        sif.out_ready = 1'b0;
      end else begin
        sif.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      held_pending = sif.out_valid && !sif.out_ready;
      held_d = sif.out_data;
      held_l = sif.out_last;
      if (sif.out_valid && sif.out_ready) begin
        got.push_back(sif.out_data);
        if (sif.out_last) begin last_cnt++; last_pos = got.size() - 1; end
      end
      if (done) dones++;
      if (dones > 0) post++;
      sort_done = (repulse && got.size() == 4);
      if (reset_at >= 0 && got.size() == reset_at) begin
        reset = 1'b1; sif.out_ready = 1'b0;
        @(negedge clk);
        chk_all_zero(tn);
        chk({tn, " no_done_before_reset"}, dones, 0);
        reset = 1'b0; sort_done = 1'b0;
        return;
      end
    end
    chk({tn, " word_count"}, got.size(), N);
    for (int i = 0; i < N && i < got.size(); i++)
      chk($sformatf("%s word%0d", tn, i), got[i], exp_q[i]);
    chk({tn, " last_count"}, last_cnt, 1);
    chk({tn, " last_pos"}, last_pos, N - 1);
    chk({tn, " done_pulses"}, dones, 1);
    chk({tn, " min"}, min_o, e_min);
    chk({tn, " max"}, max_o, e_max);
    chk({tn, " median"}, median_o, e_med);
    chk({tn, " range"}, range_o, e_max - e_min);
    chk({tn, " sum"}, sum_o, e_sum);
    chk({tn, " stats_valid_idle"}, stats_valid, 1);
    chk({tn, " busy_idle"}, busy, 0);
  endtask

  initial begin
    reset = 1'b1; sort_done = 1'b0; sif.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;

    load_frame(0);
    run_frame("t1", -1, 0, 1'b0, 1'b0, -1);
    chk("t1 min_const", min_o, 32'h00);
    chk("t1 max_const", max_o, 32'h0F);
    chk("t1 median_const", median_o, 32'h07);
    chk("t1 range_const", range_o, 32'h0F);
    chk("t1 sum_const", sum_o, 32'h078);

    load_frame(1);
    run_frame("t2", -1, 0, 1'b0, 1'b0, -1);
    chk("t2 sum_const", sum_o, 32'hFF0);
    chk("t2 median_const", median_o, 32'hFF);
    chk("t2 range_const", range_o, 32'h00);

    load_frame(2);
    run_frame("t3", 3, 5, 1'b0, 1'b0, -1);

    load_frame(2);
    run_frame("t4", -1, 0, 1'b0, 1'b1, -1);

    load_frame(2);
    run_frame("t5", -1, 0, 1'b0, 1'b0, 8);
    load_frame(2);
    run_frame("t5b", -1, 0, 1'b0, 1'b0, -1);

    for (int k = 0; k < 3; k++) begin
      load_frame(2);
      run_frame($sformatf("rnd%0d", k), -1, 0, 1'b1, 1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
